// File: rtl/tty_char_writer.sv
// Terminal front-end: turns a byte stream into VRAM character writes at the cursor,
// handling CR/LF/BS/FF and clearing lines or the whole screen with BLANK.
module tty_char_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 25,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_vram_data,
    output logic [10:0] o_vram_adr,
    output logic        o_vram_we,
    output logic [10:0] o_cursor_adr,
    output logic        o_cursor_on
);

    typedef enum logic [1:0] {CLR_SCR, IDLE, WRITE, CLR_LINE} state_t;

    localparam logic [11:0] SCR_N    = 12'(COLS * ROWS);
    localparam logic [11:0] LINE_N   = 12'(COLS);
    localparam logic [10:0] COLS_A   = 11'(COLS);
    localparam logic [10:0] LAST_COL = 11'(COLS - 1);
    localparam logic [10:0] LAST_ROW = 11'(ROWS - 1);

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [10:0] row_q, row_d;
    logic [10:0] base_q, base_d;
    logic [10:0] cur_q, cur_d;
    logic [11:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [10:0] adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        nl, ff;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= CLR_SCR;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;
        nl      = 1'b0;
        ff      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (i_data >= 8'h20) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        adr_d   = cur_q;
                        dat_d   = i_data;
                    end else begin
                        case (i_data)
                            8'h0D:   col_d = '0;
                            8'h0A:   nl = 1'b1;
                            8'h08:   if (col_q != '0) col_d = col_q - 11'd1;
                            8'h0C:   ff = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (col_q == LAST_COL) begin
                    nl = 1'b1;
                end else begin
                    col_d   = col_q + 11'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                // Entry into a clear already issued write 0, so cnt_q counts issued writes.
                if (cnt_q == ((state_q == CLR_SCR) ? SCR_N : LINE_N)) begin
                    state_d = IDLE;
                end else begin
                    we_d  = 1'b1;
                    dat_d = BLANK;
                    adr_d = ((state_q == CLR_LINE) ? base_q : 11'd0) + cnt_q[10:0];
                    cnt_d = cnt_q + 12'd1;
                end
            end
        endcase

        if (nl) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
                row_d  = '0;
                base_d = '0;
            end else begin
                row_d  = row_q + 11'd1;
                base_d = base_q + COLS_A;
            end
            state_d = CLR_LINE;
            we_d    = 1'b1;
            dat_d   = BLANK;
            adr_d   = base_d;
            cnt_d   = 12'd1;
        end

        if (ff) begin
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
            state_d = CLR_SCR;
            we_d    = 1'b1;
            dat_d   = BLANK;
            adr_d   = '0;
            cnt_d   = 12'd1;
        end

        cur_d = base_d + col_d;
    end

    always_comb begin
        o_ready     = (state_q == IDLE);
        o_cursor_on = (state_q == IDLE) || (state_q == WRITE);
    end

    assign o_vram_we    = we_q;
    assign o_vram_adr   = adr_q;
    assign o_vram_data  = dat_q;
    assign o_cursor_adr = cur_q;

endmodule

// File: tb/tb_tty_char_writer.sv
// Bench for tty_char_writer: a queue of expected per-cycle port values built from
// the terminal rules, compared every cycle, plus literal cursor/write-count checks.
module tb_tty_char_writer;
    localparam int         COLS  = 80;
    localparam int         ROWS  = 25;
    localparam logic [7:0] BLANK = 8'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready, o_vram_we, o_cursor_on;
    logic [7:0]  o_vram_data;
    logic [10:0] o_vram_adr, o_cursor_adr;

    tty_char_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_vram_data(o_vram_data), .o_vram_adr(o_vram_adr),
        .o_vram_we(o_vram_we), .o_cursor_adr(o_cursor_adr), .o_cursor_on(o_cursor_on)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One entry per cycle in which the port must show a VRAM write.
    typedef struct {
        int adr;
        int dat;
        int cur;
        int on;
    } ent_t;

    ent_t q[$];
    int   mrow = 0, mcol = 0;
    bit   pre = 1'b1;

    function automatic int mcur();
        return mrow * COLS + mcol;
    endfunction

    function automatic void push_clear(input int base, input int n, input int cur);
        for (int i = 0; i < n; i++) q.push_back('{base + i, BLANK, cur, 0});
    endfunction

    function automatic void newline();
        mcol = 0;
        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
        push_clear(mrow * COLS, COLS, mrow * COLS);
    endfunction

    function automatic void accept(input int b);
        if (b >= 32) begin
            q.push_back('{mcur(), b, mcur(), 1});
            if (mcol < COLS - 1) mcol++;
            else newline();
        end else if (b == 8'h0D) mcol = 0;
        else if (b == 8'h0A) newline();
        else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (b == 8'h0C) begin
            mrow = 0;
            mcol = 0;
            push_clear(0, COLS * ROWS, 0);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mrow = 0;
            mcol = 0;
            pre  = 1'b1;
            push_clear(0, COLS * ROWS, 0);
        end else if (pre) pre = 1'b0;
        else if (q.size() > 0) void'(q.pop_front());
        else if (i_valid) accept(int'(i_data));
    end

    int wr_cnt = 0;
    int last_adr = -1, last_dat = -1;

    always @(negedge clk) begin
        if (o_vram_we) begin
            wr_cnt++;
            last_adr = int'(o_vram_adr);
            last_dat = int'(o_vram_data);
        end
        if (!rst_n || pre) begin
            chk("rst_we", int'(o_vram_we), 0);
            chk("rst_ready", int'(o_ready), 0);
            chk("rst_on", int'(o_cursor_on), 0);
            chk("rst_cur", int'(o_cursor_adr), 0);
            chk("rst_adr", int'(o_vram_adr), 0);
            chk("rst_dat", int'(o_vram_data), 0);
        end else if (q.size() > 0) begin
            chk("wr_we", int'(o_vram_we), 1);
            chk("wr_ready", int'(o_ready), 0);
            chk("wr_adr", int'(o_vram_adr), q[0].adr);
            chk("wr_dat", int'(o_vram_data), q[0].dat);
            chk("wr_cur", int'(o_cursor_adr), q[0].cur);
            chk("wr_on", int'(o_cursor_on), q[0].on);
        end else begin
            chk("idle_we", int'(o_vram_we), 0);
            chk("idle_ready", int'(o_ready), 1);
            chk("idle_on", int'(o_cursor_on), 1);
            chk("idle_cur", int'(o_cursor_adr), mcur());
        end
    end

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk); #1;
        while (!o_ready && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (!o_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready(2 * COLS * ROWS + 100);
        i_valid = 1'b1;
        i_data  = b;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    int w0;
    int ff_left = 1;
    int r;
    logic [7:0] b;
    logic [7:0] ctl [4] = '{8'h00, 8'h07, 8'h1B, 8'h09};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_ready(COLS * ROWS + 100);
        chk("init_wr_cnt", wr_cnt, 2000);
        chk("init_last_adr", last_adr, 1999);
        chk("init_last_dat", last_dat, 32);
        chk("init_cur", int'(o_cursor_adr), 0);
        chk("init_on", int'(o_cursor_on), 1);

        send(8'h41); send(8'h42);
        wait_ready(10);
        chk("ab_cur", int'(o_cursor_adr), 2);
        chk("ab_last_dat", last_dat, 8'h42);

        send(8'h0D);
        w0 = wr_cnt;
        for (int i = 0; i < COLS; i++) send(8'h30 + 8'(i % 10));
        wait_ready(200);
        chk("line_wr_cnt", wr_cnt - w0, 160);
        chk("line_last_adr", last_adr, 159);
        chk("line_cur", int'(o_cursor_adr), 80);

        for (int i = 0; i < 23; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61);
        wait_ready(10);
        chk("r24_cur", int'(o_cursor_adr), 1925);
        send(8'h0D);
        wait_ready(10);
        chk("cr_cur", int'(o_cursor_adr), 1920);
        send(8'h0A);
        wait_ready(200);
        chk("lf_wrap_cur", int'(o_cursor_adr), 0);
        chk("lf_wrap_last_adr", last_adr, 79);

        w0 = wr_cnt;
        send(8'h08);
        wait_ready(10);
        chk("bs0_cur", int'(o_cursor_adr), 0);
        chk("bs0_nowr", wr_cnt - w0, 0);
        send(8'h0A); send(8'h78); send(8'h79); send(8'h7A); send(8'h08);
        wait_ready(10);
        chk("bs3_cur", int'(o_cursor_adr), 82);
        w0 = wr_cnt;
        send(8'h07);
        wait_ready(10);
        chk("bel_cur", int'(o_cursor_adr), 82);
        chk("bel_nowr", wr_cnt - w0, 0);

        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 70) b = 8'($urandom_range(32, 255));
            else if (r < 78) b = 8'h0D;
            else if (r < 86) b = 8'h0A;
            else if (r < 93) b = 8'h08;
            else if (r < 99 || ff_left == 0) b = ctl[$urandom_range(0, 3)];
            else begin
                b = 8'h0C;
                ff_left--;
            end
            send(b);
        end
        for (int i = 0; i < 7; i++) send(8'h55);
        send(8'h0A);
        send(8'h0C);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we", int'(o_vram_we), 0);
        chk("async_ready", int'(o_ready), 0);
        chk("async_adr", int'(o_vram_adr), 0);
        chk("async_dat", int'(o_vram_data), 0);
        chk("async_cur", int'(o_cursor_adr), 0);
        chk("async_on", int'(o_cursor_on), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        w0 = wr_cnt;
        wait_ready(COLS * ROWS + 100);
        chk("rerun_wr_cnt", wr_cnt - w0, 2000);
        chk("rerun_last_adr", last_adr, 1999);
        chk("rerun_cur", int'(o_cursor_adr), 0);
        send(8'h5A);
        wait_ready(10);
        chk("post_cur", int'(o_cursor_adr), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tty_char_writer.md
# tty_char_writer

Terminal front-end for the VGA text controller: accepts a byte stream (e.g. from the UART receiver) over a valid/ready handshake, interprets printable characters and a small set of control codes, and writes character codes into VRAM at the current cursor position. Drives the VRAM write port and the cursor address/enable consumed by the text renderer. Replaces the fixed-pattern VRAM writer as the producer on that port.

## Interface
Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen; COLS*ROWS ≤ 2048.
- BLANK, 8'h20, fill code used by clear operations.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data  in  8  incoming character byte.
- i_valid  in  1  i_data valid.
- o_ready  out  1  block can accept a byte this cycle.
- o_vram_data  out  8  VRAM write data.
- o_vram_adr  out  11  VRAM write address, row*COLS+col.
- o_vram_we  out  1  VRAM write strobe, one write per cycle high.
- o_cursor_adr  out  11  current cursor address.
- o_cursor_on  out  1  cursor display enable.

## Operation
- States: CLR_SCR, IDLE, WRITE, CLR_LINE.
- Internal: col (0..COLS-1), row (0..ROWS-1), row_base = row*COLS maintained incrementally (no multiplier); o_cursor_adr = row_base + col, registered.
- o_ready = 1 only in IDLE. Byte accepted on a rising edge with i_valid & o_ready.
- Decoding in IDLE on accept:
  - 8'h20..8'hFF printable → WRITE (o_vram_we=1, o_vram_adr=cursor, o_vram_data=byte).
  - 8'h0D CR → col=0, stay IDLE.
  - 8'h0A LF → newline (see below).
  - 8'h08 BS → col=col-1 if col>0, else unchanged; no erase.
  - 8'h0C FF → cursor=0, CLR_SCR.
  - any other code below 8'h20 → consumed, ignored.
- WRITE (1 cycle): o_vram_we drops; if col<COLS-1 then col+1, → IDLE; else newline.
- Newline: col=0; row=row+1, or 0 when row=ROWS-1 (wrap to top, no scroll); → CLR_LINE.
- CLR_LINE: COLS consecutive cycles with o_vram_we=1, o_vram_data=BLANK, o_vram_adr = new row_base .. row_base+COLS-1; then → IDLE.
- CLR_SCR: COLS*ROWS consecutive writes of BLANK, addresses 0 .. COLS*ROWS-1; then → IDLE.
- o_cursor_on = 1 in IDLE and WRITE; 0 in CLR_SCR and CLR_LINE.
- Input bytes are never dropped: any i_valid while o_ready=0 is held off by the source.

## Timing
- Reset values: o_ready=0, o_vram_we=0, o_vram_adr=0, o_vram_data=0, o_cursor_adr=0, o_cursor_on=0; state=CLR_SCR, col=row=0.
- After reset release: first BLANK write in the cycle after the first clock edge; CLR_SCR lasts COLS*ROWS cycles (2000 default); o_ready rises the cycle after the last write.
- Printable byte accepted at edge E0: write visible on the VRAM port from E0 to E1; cursor advances and o_ready returns at E1. Throughput 1 byte / 2 cycles without wrap.
- CR, BS, ignored codes: single cycle, o_ready stays 1, no VRAM write; cursor updated at the accepting edge.
- LF or wrapping printable: cursor moves to new row start at the edge entering CLR_LINE; o_ready low for COLS cycles.
- FF: o_cursor_adr=0 at the accepting edge; o_ready low for COLS*ROWS cycles.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously); any in-progress clear is abandoned; after release a full CLR_SCR is rerun.
- Address arithmetic: 11-bit unsigned; never exceeds COLS*ROWS-1.

## Test plan
- Reset release → 2000 writes of 8'h20 to addresses 0..1999, o_cursor_on=0 throughout, then o_ready=1, o_cursor_adr=0, o_cursor_on=1.
- Send 'A','B' (8'h41,8'h42) → writes 8'h41@0, 8'h42@1; o_cursor_adr=2; o_ready low exactly one cycle per byte.
- Send 80 printable bytes from col 0 row 0 → last write @79, then 80 BLANK writes @80..159, o_cursor_adr=80.
- Cursor at row 24 col 5, send CR then LF → o_cursor_adr=1920 after CR, then 0 after LF with BLANK writes @0..79.
- BS at col 0 → cursor unchanged, no write; BS at col 3 row 1 → o_cursor_adr=82; send 8'h07 → no write, cursor unchanged.
- Send FF mid-screen, assert i_rst_n low 100 cycles into the clear → outputs at reset values immediately; after release a full 2000-write clear restarts from address 0.
